// File: rtl/oam_dma_ctrl.sv
// OAM sprite DMA sequencer: copies XFER_LEN bytes from CPU page {page,8'h00} into OAM while stalling the CPU.
// Build option: define OAM_DMA_ALIGN_EN to add the ALIGN wait state (NES-accurate 513/514-cycle stall).
module oam_dma_ctrl #(
    parameter int XFER_LEN = 256,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              dma_start,
    input  logic [7:0]        dma_page,
    input  logic [7:0]        oam_base,
    input  logic [7:0]        mem_data_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              oam_we,
    output logic [7:0]        oam_addr,
    output logic [7:0]        oam_data,
    output logic              busy,
    output logic              cpu_rdy,
    output logic              dma_done,
    output logic [1:0]        dbg_state_o,
    output logic              dbg_parity_o
);
    localparam int IDX_W = $clog2(XFER_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
`ifdef OAM_DMA_ALIGN_EN
        , ALIGN = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       page_q, page_d;
    logic [7:0]       base_q, base_d;
    logic             parity_q, parity_d;
    logic             done_q, done_d;
    logic [7:0]       idx_ext;
`ifdef OAM_DMA_ALIGN_EN
    logic             extra_q, extra_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            page_q   <= '0;
            base_q   <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            extra_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            base_q   <= base_d;
            parity_q <= parity_d;
            done_q   <= done_d;
`ifdef OAM_DMA_ALIGN_EN
            extra_q  <= extra_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        page_d   = page_q;
        base_d   = base_q;
        done_d   = 1'b0;
        parity_d = ce ? ~parity_q : parity_q;
`ifdef OAM_DMA_ALIGN_EN
        extra_d  = extra_q;
`endif
        case (state_q)
            IDLE: begin
                // A start colliding with the done pulse is dropped, not queued.
                if (dma_start && !done_q) begin
                    page_d = dma_page;
                    base_d = oam_base;
                    idx_d  = '0;
`ifdef OAM_DMA_ALIGN_EN
                    extra_d = parity_q;
                    state_d = ALIGN;
`else
                    state_d = READ;
`endif
                end
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
                if (ce) begin
                    if (extra_q) extra_d = 1'b0;
                    else         state_d = READ;
                end
            end
`endif
            READ: begin
                if (ce) state_d = WRITE;
            end
            WRITE: begin
                if (ce) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idx_ext      = 8'(idx_q);
    assign mem_addr     = ADDR_W'({page_q, idx_ext});
    assign mem_rd       = ce && (state_q == READ);
    assign oam_we       = ce && (state_q == WRITE);
    assign oam_addr     = base_q + idx_ext;
    assign oam_data     = (state_q == WRITE) ? mem_data_in : 8'h00;
    assign busy         = (state_q != IDLE);
    assign cpu_rdy      = ~busy;
    assign dma_done     = done_q;
    assign dbg_state_o  = state_q;
    assign dbg_parity_o = parity_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: bus/OAM models on the falling edge, stimulus 1 time unit after the rising edge.
module tb_oam_dma_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        dma_start = 1'b0;
  logic [7:0]  dma_page = 8'h00;
  logic [7:0]  oam_base = 8'h00;
  logic [7:0]  rd_data = 8'h00;
  logic [15:0] mem_addr;
  logic        mem_rd, oam_we, busy, cpu_rdy, dma_done, dbg_parity;
  logic [7:0]  oam_addr, oam_data;
  logic [1:0]  dbg_state;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ALIGN_ON = 1;
`else
  localparam int ALIGN_ON = 0;
`endif

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .ce(ce), .dma_start(dma_start),
    .dma_page(dma_page), .oam_base(oam_base), .mem_data_in(rd_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .oam_we(oam_we),
    .oam_addr(oam_addr), .oam_data(oam_data), .busy(busy),
    .cpu_rdy(cpu_rdy), .dma_done(dma_done),
    .dbg_state_o(dbg_state), .dbg_parity_o(dbg_parity)
  );

  always #5 clk = ~clk;

  logic [7:0] oam [256];
  int n_chk = 0, n_err = 0;
  int busy_clks, busy_ce, we_count, done_count, page_err, bad_we;
  logic [7:0] page_exp = 8'h00;
  logic par_m = 1'b0;
  logic acc_par = 1'b0;
  logic ce_alt = 1'b0;

  // Source memory content: page 2 holds i, each later page adds 8'h11.
  function automatic logic [7:0] data_of(input logic [15:0] a);
    logic [7:0] pg;
    pg = a[15:8] - 8'd2;
    return a[7:0] + pg * 8'h11;
  endfunction

  // CPU-cycle parity as seen by the DMA engine.
  always @(posedge clk) begin
    if (reset) par_m <= 1'b0;
    else if (ce) par_m <= ~par_m;
  end

  // Bus and OAM models plus activity counters.
  always @(negedge clk) begin
    if (mem_rd) begin
      rd_data <= data_of(mem_addr);
      if (mem_addr[15:8] != page_exp) page_err++;
    end
    if (oam_we) begin
      oam[oam_addr] = oam_data;
      we_count++;
      if (!ce) bad_we++;
    end
    if (busy) begin
      busy_clks++;
      if (ce) busy_ce++;
    end
    if (dma_done) done_count++;
  end

  task automatic check(input string tag, input int got, input int expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ce_alt) ce = ~ce;
    end
  endtask

  task automatic clear_counts();
    busy_clks = 0; busy_ce = 0; we_count = 0;
    done_count = 0; page_err = 0; bad_we = 0;
  endtask

  task automatic fill_oam(input logic [7:0] pg, input logic [7:0] base);
    for (int i = 0; i < 256; i++) oam[8'(base + 8'(i))] = ~data_of({pg, 8'(i)});
  endtask

  function automatic int oam_errs(input logic [7:0] pg, input logic [7:0] base);
    int e = 0;
    for (int i = 0; i < 256; i++)
      if (oam[8'(base + 8'(i))] !== data_of({pg, 8'(i)})) e++;
    return e;
  endfunction

  function automatic int exp_ce_cycles();
    return 512 + (ALIGN_ON != 0 ? 1 + int'(acc_par) : 0);
  endfunction

  task automatic start(input logic [7:0] pg, input logic [7:0] base);
    clear_counts();
    fill_oam(pg, base);
    page_exp = pg;
    acc_par = par_m;
    dma_start = 1'b1; dma_page = pg; oam_base = base;
    tick(1);
    dma_start = 1'b0; dma_page = 8'hEE; oam_base = 8'hEE;
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (!dma_done && i < 3000) begin
      tick(1);
      i++;
    end
    if (!dma_done) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int i = 0;
    while (we_count < n && i < 3000) begin
      tick(1);
      i++;
    end
    if (we_count < n) check({tag, "_timeout"}, we_count, n);
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_cpu_rdy", 32'(cpu_rdy), 1);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_oam_we", 32'(oam_we), 0);
    check("rst_done", 32'(dma_done), 0);
    check("rst_addrs", 32'({mem_addr, oam_addr, oam_data}), 0);
    reset = 1'b0;
    tick(2);

    // Test 1: plain copy of page 2 into OAM from base 0.
    start(8'h02, 8'h00);
    check("t1_busy_rise", 32'(busy), 1);
    check("t1_cpu_rdy_low", 32'(cpu_rdy), 0);
    check("t1_first_rd", 32'(mem_rd), ALIGN_ON != 0 ? 0 : 1);
    check("t1_first_addr", 32'(mem_addr), 32'h0200);
    wait_done("t1");
    dma_start = 1'b1; dma_page = 8'h05; oam_base = 8'h00;
    tick(1);
    dma_start = 1'b0;
    check("t1_start_on_done_ignored", 32'(busy), 0);
    tick(2);
    check("t1_busy_clks", busy_clks, exp_ce_cycles());
    check("t1_done_count", done_count, 1);
    check("t1_we_count", we_count, 256);
    check("t1_oam", oam_errs(8'h02, 8'h00), 0);
    check("t1_cpu_rdy", 32'(cpu_rdy), 1);

    // Test 2: OAM address wraps from base FC, source stays in page 3.
    start(8'h03, 8'hFC);
    wait_done("t2");
    tick(2);
    check("t2_oam_fc", 32'(oam[8'hFC]), 32'h11);
    check("t2_oam_00", 32'(oam[8'h00]), 32'h15);
    check("t2_oam", oam_errs(8'h03, 8'hFC), 0);
    check("t2_page_err", page_err, 0);
    check("t2_done_count", done_count, 1);

    // Test 3: a second start mid-transfer is ignored.
    start(8'h03, 8'h00);
    wait_writes(100, "t3");
    dma_start = 1'b1; dma_page = 8'h05; oam_base = 8'h40;
    tick(1);
    dma_start = 1'b0;
    wait_done("t3");
    tick(2);
    check("t3_oam", oam_errs(8'h03, 8'h00), 0);
    check("t3_page_err", page_err, 0);
    check("t3_busy_clks", busy_clks, exp_ce_cycles());
    check("t3_done_count", done_count, 1);

    // Test 4: reset at byte 40, then a full transfer.
    start(8'h02, 8'h00);
    wait_writes(40, "t4");
    reset = 1'b1;
    tick(1);
    check("t4_busy", 32'(busy), 0);
    check("t4_oam_we", 32'(oam_we), 0);
    check("t4_mem_rd", 32'(mem_rd), 0);
    check("t4_cpu_rdy", 32'(cpu_rdy), 1);
    reset = 1'b0;
    tick(5);
    check("t4_no_done", done_count, 0);
    start(8'h04, 8'h10);
    wait_done("t4b");
    tick(2);
    check("t4_oam", oam_errs(8'h04, 8'h10), 0);
    check("t4_done_count", done_count, 1);

    // Test 5: ce alternating 1/0 stretches the transfer without losing bytes.
    ce = 1'b1;
    ce_alt = 1'b1;
    start(8'h02, 8'h00);
    wait_done("t5");
    tick(2);
    ce_alt = 1'b0;
    ce = 1'b1;
    check("t5_oam", oam_errs(8'h02, 8'h00), 0);
    check("t5_busy_clks", busy_clks, 2 * exp_ce_cycles());
    check("t5_busy_ce", busy_ce, exp_ce_cycles());
    check("t5_we_count", we_count, 256);
    check("t5_bad_we", bad_we, 0);
    check("t5_done_count", done_count, 1);

    // Test 6: stall length depends on parity only when alignment is built in.
    for (int p = 0; p < 2; p++) begin
      tick(1);
      if (par_m != 1'(p)) tick(1);
      start(8'h02, 8'h00);
      check($sformatf("t6_first_rd_p%0d", p), 32'(mem_rd), ALIGN_ON != 0 ? 0 : 1);
      wait_done($sformatf("t6_p%0d", p));
      tick(2);
      check($sformatf("t6_busy_p%0d", p), busy_clks, ALIGN_ON != 0 ? 513 + p : 512);
      check($sformatf("t6_oam_p%0d", p), oam_errs(8'h02, 8'h00), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
